// File: rtl/mccoy_host.sv
// mccoy_host: host driver for the McCoy tile's 8-bit io pair.
// Loads a program, clocks and resets the CPU, feeds instructions.
//
// Ports:
//   clk, reset         system clock, sync active-high reset
//   load_valid/data    program word in (opcode[2:0], field[5:3])
//   load_ready         word accepted (IDLE only)
//   run, run_cycles    start pulse and CPU cycle count (0 = open)
//   stop               end the run after the current low phase
//   cpu_io_in          [0]=cpu clk, [1]=cpu reset, [7:2]=instr
//   cpu_io_out         PC while cpu clk high, x8 while low
//   pc_out, x8_out     last sampled PC / x8
//   sample_valid       pulse when x8_out updates
//   busy, done         run in progress / end-of-run pulse
//   cycles             CPU rising edges in RUN (saturating)
// Optional MCCOY_HOST_BKPT_EN adds bkpt_en, bkpt_pc, bkpt_hit.

module mccoy_host #(
  parameter int PROG_DEPTH = 32,
  parameter int HALF       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [5:0]  load_data,
  output logic        load_ready,
  input  logic        run,
  input  logic [15:0] run_cycles,
  input  logic        stop,
  output logic [7:0]  cpu_io_in,
  input  logic [7:0]  cpu_io_out,
  output logic [7:0]  pc_out,
  output logic [7:0]  x8_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] cycles
`ifdef MCCOY_HOST_BKPT_EN
  ,
  input  logic        bkpt_en,
  input  logic [7:0]  bkpt_pc,
  output logic        bkpt_hit
`endif
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPURST,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [5:0]    mem [PROG_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          cclk_q, cclk_d;
  logic          crst_q, crst_d;
  logic [5:0]    instr_q, instr_d;
  logic [7:0]    pc_q, pc_d;
  logic [7:0]    x8_q, x8_d;
  logic          sv_q, sv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdy_q, rdy_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [15:0]   n_q, n_d;
  logic          stop_q, stop_d;
  logic          rper_q, rper_d;
  logic          bpend_q, bpend_d;
  logic          wr_en;
  logic          half_end;
  logic          end_now;
  logic          bp_match;
`ifdef MCCOY_HOST_BKPT_EN
  logic          bhit_q, bhit_d;

  assign bp_match = bkpt_en && (cpu_io_out == bkpt_pc);
`else
  assign bp_match = 1'b0;
`endif

  assign half_end = (hcnt_q == HLAST);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    hcnt_d   = hcnt_q;
    cclk_d   = cclk_q;
    crst_d   = crst_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    x8_d     = x8_q;
    sv_d     = 1'b0;
    done_d   = 1'b0;
    cyc_d    = cyc_q;
    n_d      = n_q;
    stop_d   = stop_q;
    rper_d   = rper_q;
    bpend_d  = bpend_q;
    wr_en    = 1'b0;
    end_now  = 1'b0;
`ifdef MCCOY_HOST_BKPT_EN
    bhit_d   = bhit_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cclk_d  = 1'b0;
        crst_d  = 1'b1;
        instr_d = '0;
        if (load_valid && rdy_q) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
        end
        if (run) begin
          state_d = S_CPURST;
          n_d     = run_cycles;
          cyc_d   = '0;
          cclk_d  = 1'b1;
          hcnt_d  = '0;
          rper_d  = 1'b0;
          stop_d  = 1'b0;
          bpend_d = 1'b0;
`ifdef MCCOY_HOST_BKPT_EN
          bhit_d  = 1'b0;
`endif
        end
      end
      S_CPURST, S_RUN: begin
        hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
        if (stop) stop_d = 1'b1;
        // End of high phase: capture PC, fetch its word.
        if (half_end && cclk_q) begin
          cclk_d  = 1'b0;
          pc_d    = cpu_io_out;
          instr_d = mem[cpu_io_out[AW-1:0]];
          if (state_q == S_RUN && bp_match)
            bpend_d = 1'b1;
        end
        // End of low phase: capture x8, then rise or finish.
        if (half_end && !cclk_q) begin
          if (state_q == S_RUN) begin
            x8_d = cpu_io_out;
            sv_d = 1'b1;
          end
          end_now = stop_q || stop || bpend_q ||
                    (state_q == S_RUN && n_q != '0 &&
                     cyc_q == n_q);
          if (end_now) begin
            state_d = S_DONE;
            crst_d  = 1'b1;
            instr_d = '0;
            done_d  = 1'b1;
`ifdef MCCOY_HOST_BKPT_EN
            bhit_d  = bpend_q;
`endif
          end else begin
            cclk_d = 1'b1;
            if (state_q == S_RUN || rper_q)
              cyc_d = (cyc_q == 16'hFFFF) ? cyc_q
                                          : cyc_q + 16'd1;
            if (state_q == S_CPURST) begin
              if (rper_q) begin
                state_d = S_RUN;
                crst_d  = 1'b0;
              end else begin
                rper_d = 1'b1;
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cclk_d  = 1'b0;
        crst_d  = 1'b1;
        instr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d == S_CPURST) ||
             (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      hcnt_q  <= '0;
      cclk_q  <= 1'b0;
      crst_q  <= 1'b1;
      instr_q <= '0;
      pc_q    <= '0;
      x8_q    <= '0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      cyc_q   <= '0;
      n_q     <= '0;
      stop_q  <= 1'b0;
      rper_q  <= 1'b0;
      bpend_q <= 1'b0;
`ifdef MCCOY_HOST_BKPT_EN
      bhit_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      hcnt_q  <= hcnt_d;
      cclk_q  <= cclk_d;
      crst_q  <= crst_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      x8_q    <= x8_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      cyc_q   <= cyc_d;
      n_q     <= n_d;
      stop_q  <= stop_d;
      rper_q  <= rper_d;
      bpend_q <= bpend_d;
`ifdef MCCOY_HOST_BKPT_EN
      bhit_q  <= bhit_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PROG_DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wptr_q] <= load_data;
    end
  end

  assign cpu_io_in    = {instr_q, crst_q, cclk_q};
  assign load_ready   = rdy_q;
  assign pc_out       = pc_q;
  assign x8_out       = x8_q;
  assign sample_valid = sv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cycles       = cyc_q;
`ifdef MCCOY_HOST_BKPT_EN
  assign bkpt_hit     = bhit_q;
`endif

endmodule

// File: tb/tb_mccoy_host.sv
// tb_mccoy_host: scoreboard bench for mccoy_host.
// Stub CPU counts PC per cpu rising edge; x8 = (PC+base)^0x5A.

module tb_mccoy_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [5:0]  load_data = '0;
  logic        load_ready;
  logic        run = 1'b0;
  logic [15:0] run_cycles = '0;
  logic        stop = 1'b0;
  logic [7:0]  cpu_io_in;
  logic [7:0]  cpu_io_out;
  logic [7:0]  pc_out;
  logic [7:0]  x8_out;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic [15:0] cycles;
`ifdef MCCOY_HOST_BKPT_EN
  logic        bkpt_en = 1'b0;
  logic [7:0]  bkpt_pc = '0;
  logic        bkpt_hit;
`endif

  mccoy_host #(
    .PROG_DEPTH(32),
    .HALF(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .run(run),
    .run_cycles(run_cycles),
    .stop(stop),
    .cpu_io_in(cpu_io_in),
    .cpu_io_out(cpu_io_out),
    .pc_out(pc_out),
    .x8_out(x8_out),
    .sample_valid(sample_valid),
    .busy(busy),
    .done(done),
    .cycles(cycles)
`ifdef MCCOY_HOST_BKPT_EN
    ,
    .bkpt_en(bkpt_en),
    .bkpt_pc(bkpt_pc),
    .bkpt_hit(bkpt_hit)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] s_pc = '0;
  logic [7:0] s_x8 = '0;
  logic [7:0] s_base = '0;

  always @(posedge cpu_io_in[0]) begin
    if (cpu_io_in[1]) s_pc = '0;
    else s_pc = s_pc + 8'd1;
    s_x8 = (s_pc + s_base) ^ 8'h5A;
  end

  assign cpu_io_out = cpu_io_in[0] ? 8'(s_pc + s_base) : s_x8;

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  pc;
    logic [7:0]  x8;
    logic [15:0] blen;
    logic [15:0] nsv;
    logic        bk;
  } res_t;

  res_t       res_q[$];
  logic [5:0] ins_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic exp_ins(input int n, input logic [47:0] v);
    for (int i = 0; i < n; i++)
      ins_q.push_back(v[6*(n-1-i) +: 6]);
  endtask

  task automatic exp_res(input logic [15:0] cyc,
                         input logic [7:0] pc,
                         input logic [7:0] x8,
                         input logic [15:0] blen,
                         input logic [15:0] nsv,
                         input logic bk);
    res_t r;
    r.cyc = cyc; r.pc = pc; r.x8 = x8;
    r.blen = blen; r.nsv = nsv; r.bk = bk;
    res_q.push_back(r);
  endtask

  // Monitor: instr at each cpu rise, run summary at done.
  logic       prev_cclk = 1'b0;
  int         bcnt = 0;
  int         svcnt = 0;
  bit         mon_off = 1'b0;
  res_t       mr;
  logic [5:0] mi;

  always @(negedge clk) begin
    if (reset) begin
      prev_cclk = 1'b0;
      bcnt = 0;
      svcnt = 0;
    end else begin
      if (cpu_io_in[0] && !prev_cclk && !mon_off) begin
        if (ins_q.size() == 0) begin
          chk("extra_rise", 32'(cpu_io_in[0]), 32'd0);
        end else begin
          mi = ins_q.pop_front();
          chk("instr", 32'(cpu_io_in[7:2]), 32'(mi));
        end
      end
      prev_cclk = cpu_io_in[0];
      if (busy) bcnt++;
      if (sample_valid) svcnt++;
      if (done) begin
        done_cnt++;
        if (res_q.size() == 0) begin
          chk("extra_done", 32'(done), 32'd0);
        end else begin
          mr = res_q.pop_front();
          chk("cycles", 32'(cycles), 32'(mr.cyc));
          chk("pc_out", 32'(pc_out), 32'(mr.pc));
          chk("x8_out", 32'(x8_out), 32'(mr.x8));
          chk("busy_len", 32'(bcnt), 32'(mr.blen));
          chk("sv_count", 32'(svcnt), 32'(mr.nsv));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("io_at_done", 32'(cpu_io_in), 32'h02);
`ifdef MCCOY_HOST_BKPT_EN
          chk("bkpt_hit", 32'(bkpt_hit), 32'(mr.bk));
`endif
        end
        bcnt = 0;
        svcnt = 0;
      end
    end
  end

  task automatic load_word(input logic [5:0] d);
    load_valid = 1'b1;
    load_data = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] n);
    run = 1'b1;
    run_cycles = n;
    @(negedge clk);
    run = 1'b0;
    chk("busy_after_run", 32'(busy), 32'd1);
    chk("ready_while_busy", 32'(load_ready), 32'd0);
    chk("cpu_rst_held", 32'(cpu_io_in[1]), 32'd1);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done_cnt), 32'(target));
    @(negedge clk);
  endtask

  initial begin
    int t;
    int nd;
    repeat (2) @(negedge clk);
    chk("rst_io", 32'(cpu_io_in), 32'h02);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sv", 32'(sample_valid), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_x8", 32'(x8_out), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(load_ready), 32'd1);
    chk("idle_io", 32'(cpu_io_in), 32'h02);

    load_word(6'h05);
    load_word(6'h11);
    load_word(6'h2A);

    // Counted run, N=3.
    s_base = 8'h00;
    exp_ins(5, {6'h00, 6'h05, 6'h05, 6'h11, 6'h2A});
    exp_res(16'd3, 8'h03, 8'h59, 16'd20, 16'd3, 1'b0);
    start_run(16'd3);
    wait_done(1);
    chk("cycles_hold", 32'(cycles), 32'd3);
    chk("ready_back", 32'(load_ready), 32'd1);

    // Open run ended by stop mid high phase after 5 edges.
    exp_ins(7, {6'h00, 6'h05, 6'h05, 6'h11,
                6'h2A, 6'h00, 6'h00});
    exp_res(16'd5, 8'h05, 8'h5F, 16'd28, 16'd5, 1'b0);
    start_run(16'd0);
    t = 0;
    while (cycles != 16'd5 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("reach_5_edges", 32'(cycles), 32'd5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(2);

    // Fresh reset, 33-word load wraps onto mem[0].
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 33; k++)
      load_word(6'(k + 16));

    s_base = 8'h1F;
    exp_ins(4, {6'h00, 6'h2F, 6'h2F, 6'h30});
    exp_res(16'd2, 8'h21, 8'h7B, 16'd16, 16'd2, 1'b0);
    start_run(16'd2);
    wait_done(3);

    s_base = 8'h23;
    exp_ins(3, {6'h00, 6'h13, 6'h13});
    exp_res(16'd1, 8'h24, 8'h7E, 16'd12, 16'd1, 1'b0);
    start_run(16'd1);
    wait_done(4);
    nd = 4;

`ifdef MCCOY_HOST_BKPT_EN
    s_base = 8'h00;
    bkpt_en = 1'b1;
    bkpt_pc = 8'h02;
    exp_ins(4, {6'h00, 6'h30, 6'h30, 6'h11});
    exp_res(16'd2, 8'h02, 8'h58, 16'd16, 16'd2, 1'b1);
    start_run(16'd0);
    wait_done(5);
    bkpt_en = 1'b0;
    nd = 5;
`endif

    // Reset in the middle of a run.
    mon_off = 1'b1;
    run = 1'b1;
    run_cycles = 16'd0;
    @(negedge clk);
    run = 1'b0;
`ifdef MCCOY_HOST_BKPT_EN
    chk("bkpt_hit_clr", 32'(bkpt_hit), 32'd0);
`endif
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_io", 32'(cpu_io_in), 32'h02);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(nd));
    chk("abort_ready", 32'(load_ready), 32'd1);

    chk("ins_q_empty", 32'(ins_q.size()), 32'd0);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
